// File: rtl/itch_msg_body_buffer_if.sv
// Payload-side bus of the ITCH message body buffer: parser stream in, committed bytes out.
// master drives the stream and out_ready; slave is the buffer.
interface itch_msg_body_buffer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  msg_type;
    logic [15:0] msg_len;
    logic        header_valid;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        msg_commit;
    logic        msg_drop;
    logic [15:0] drop_count;

    modport master (
        output rx_data, rx_valid, msg_type, msg_len, header_valid, out_ready,
        input  out_data, out_valid, out_last, msg_commit, msg_drop, drop_count
    );

    modport slave (
        input  rx_data, rx_valid, msg_type, msg_len, header_valid, out_ready,
        output out_data, out_valid, out_last, msg_commit, msg_drop, drop_count
    );
endinterface

// File: rtl/itch_msg_body_buffer.sv
// Speculative ITCH payload byte FIFO: commit or rewind at the last byte of each message.
// Optional macro ITCH_BODY_TYPE_CHECK_EN enables the message type/length table check.
module itch_msg_body_buffer #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned PW    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    itch_msg_body_buffer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, SKIP} state_t;
    typedef logic [PW:0] ptr_t;

    state_t      state_q, state_d;
    ptr_t        rd_ptr, commit_ptr, spec_ptr;
    ptr_t        rd_next, commit_d, spec_d, fill;
    logic [15:0] remain, remain_d;
    logic [15:0] drop_count;
    logic [8:0]  mem [DEPTH];
    logic [8:0]  head_next;
    logic [7:0]  out_data;
    logic        out_last, out_valid, msg_commit, msg_drop;
    logic        full, pop, valid_next, header_ok;
    logic        wr_en, wr_last, commit_pulse, drop_pulse;

    assign fill = spec_ptr - rd_ptr;
    assign full = (fill == (PW+1)'(DEPTH));
    assign pop  = out_valid && bus.out_ready;

`ifdef ITCH_BODY_TYPE_CHECK_EN
    always_comb begin
        header_ok = 1'b0;
        case (bus.msg_type)
            8'h53:   header_ok = (bus.msg_len == 16'd11);
            8'h41:   header_ok = (bus.msg_len == 16'd35);
            8'h45:   header_ok = (bus.msg_len == 16'd30);
            8'h58:   header_ok = (bus.msg_len == 16'd22);
            8'h44:   header_ok = (bus.msg_len == 16'd18);
            default: header_ok = 1'b0;
        endcase
    end
`else
    assign header_ok = (bus.msg_len != 16'd0);
`endif

    // Next-state and pointer logic; rewind on overflow never goes below commit_ptr.
    always_comb begin
        state_d      = state_q;
        spec_d       = spec_ptr;
        commit_d     = commit_ptr;
        remain_d     = remain;
        wr_en        = 1'b0;
        wr_last      = 1'b0;
        commit_pulse = 1'b0;
        drop_pulse   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.header_valid) begin
                    if (!header_ok) begin
                        drop_pulse = 1'b1;
                    end else begin
                        remain_d = bus.msg_len;
                        state_d  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (bus.rx_valid) begin
                    remain_d = remain - 16'd1;
                    if (!full) begin
                        wr_en   = 1'b1;
                        wr_last = (remain == 16'd1);
                        spec_d  = spec_ptr + ptr_t'(1);
                        if (remain == 16'd1) begin
                            commit_d     = spec_ptr + ptr_t'(1);
                            commit_pulse = 1'b1;
                            state_d      = IDLE;
                        end
                    end else begin
                        spec_d = commit_ptr;
                        if (remain == 16'd1) begin
                            drop_pulse = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = SKIP;
                        end
                    end
                end
            end
            SKIP: begin
                if (bus.rx_valid) begin
                    remain_d = remain - 16'd1;
                    if (remain == 16'd1) begin
                        drop_pulse = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Head lookahead with bypass for a byte written and committed in the same edge.
    always_comb begin
        rd_next    = pop ? rd_ptr + ptr_t'(1) : rd_ptr;
        valid_next = (rd_next != commit_d);
        head_next  = mem[rd_next[PW-1:0]];
        if (wr_en && (spec_ptr == rd_next)) begin
            head_next = {wr_last, bus.rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[spec_ptr[PW-1:0]] <= {wr_last, bus.rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_ptr     <= '0;
            commit_ptr <= '0;
            spec_ptr   <= '0;
            remain     <= '0;
            drop_count <= '0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            msg_commit <= 1'b0;
            msg_drop   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr     <= rd_next;
            commit_ptr <= commit_d;
            spec_ptr   <= spec_d;
            remain     <= remain_d;
            out_valid  <= valid_next;
            out_data   <= valid_next ? head_next[7:0] : 8'h00;
            out_last   <= valid_next && head_next[8];
            msg_commit <= commit_pulse;
            msg_drop   <= drop_pulse;
            if (drop_pulse && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    assign bus.out_data   = out_data;
    assign bus.out_valid  = out_valid;
    assign bus.out_last   = out_last;
    assign bus.msg_commit = msg_commit;
    assign bus.msg_drop   = msg_drop;
    assign bus.drop_count = drop_count;

endmodule

// File: tb/tb_itch_msg_body_buffer.sv
// Directed bench for itch_msg_body_buffer: commit, wrap, overflow, type check, reset, zero length.
module tb_itch_msg_body_buffer;

`ifdef ITCH_BODY_TYPE_CHECK_EN
    localparam bit TC = 1'b1;
`else
    localparam bit TC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    itch_msg_body_buffer_if bus();

    itch_msg_body_buffer #(.DEPTH(64), .PW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int n_commit = 0;
    int n_drop = 0;
    int n_valid = 0;
    int c0, d0;
    logic [8:0] rxq[$];
    logic [8:0] expq[$];

    // Consumer/pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) rxq.push_back({bus.out_last, bus.out_data});
            if (bus.out_valid) n_valid++;
            if (bus.msg_commit) n_commit++;
            if (bus.msg_drop) n_drop++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hdr(input logic [7:0] t, input logic [15:0] l);
        bus.header_valid = 1'b1;
        bus.msg_type     = t;
        bus.msg_len      = l;
        bus.rx_valid     = 1'b1;
        bus.rx_data      = 8'hEE;
        tick();
        bus.header_valid = 1'b0;
        bus.rx_valid     = 1'b0;
    endtask

    task automatic msg_bytes(input int n, input logic [7:0] base, input bit keep);
        for (int i = 0; i < n; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = base + 8'(i);
            if (keep) expq.push_back({(i == n - 1), base + 8'(i)});
            tick();
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.out_ready = 1'b1;
        repeat (n) tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic check_q(input string tag);
        int n;
        check({tag, "_count"}, 32'(rxq.size()), 32'(expq.size()));
        n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(rxq[i]), 32'(expq[i]));
        end
        rxq.delete();
        expq.delete();
    endtask

    initial begin
        rst              = 1'b1;
        bus.rx_data      = '0;
        bus.rx_valid     = 1'b0;
        bus.msg_type     = '0;
        bus.msg_len      = '0;
        bus.header_valid = 1'b0;
        bus.out_ready    = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_last", 32'(bus.out_last), 0);
        check("rst_commit", 32'(bus.msg_commit), 0);
        check("rst_drop", 32'(bus.msg_drop), 0);
        check("rst_drop_count", 32'(bus.drop_count), 0);
        rst = 1'b0;
        tick();

        // 'D' 18 bytes streamed straight through
        bus.out_ready = 1'b1;
        hdr(8'h44, 16'd18);
        msg_bytes(18, 8'h00, 1'b1);
        check("t1_commit_lat", 32'(bus.msg_commit), 1);
        check("t1_valid_lat", 32'(bus.out_valid), 1);
        check("t1_first_data", 32'(bus.out_data), 32'h00);
        check("t1_first_last", 32'(bus.out_last), 0);
        repeat (25) tick();
        bus.out_ready = 1'b0;
        check("t1_commits", 32'(n_commit), 1);
        check("t1_drop_count", 32'(bus.drop_count), 0);
        check_q("t1");

        // Back-to-back 'S' pairs held until committed; four rounds wrap the pointers
        for (int r = 0; r < 4; r++) begin
            hdr(8'h53, 16'd11);
            msg_bytes(11, 8'(r * 32), 1'b1);
            hdr(8'h53, 16'd11);
            msg_bytes(11, 8'(r * 32 + 16), 1'b1);
            check($sformatf("t2_held%0d", r), 32'(rxq.size()), 0);
            drain(30);
            check_q($sformatf("t2_r%0d", r));
        end
        check("t2_commits", 32'(n_commit), 9);

        // 100-byte message overflows a 64-byte FIFO
        c0 = n_commit; d0 = n_drop; n_valid = 0;
        hdr(8'h58, 16'd100);
        msg_bytes(100, 8'h00, 1'b0);
        repeat (3) tick();
        check("t3_drops", 32'(n_drop - d0), 1);
        check("t3_commits", 32'(n_commit - c0), 0);
        check("t3_valid_seen", 32'(n_valid), 0);
        check("t3_drop_count", 32'(bus.drop_count), 1);
        drain(5);
        check_q("t3");

        // Exactly DEPTH bytes fit with nothing read (rewind restored spec_ptr)
        c0 = n_commit; d0 = n_drop;
        hdr(8'h5A, 16'd64);
        msg_bytes(64, 8'h40, !TC);
        repeat (2) tick();
        check("t4_commits", 32'(n_commit - c0), TC ? 0 : 1);
        check("t4_drops", 32'(n_drop - d0), TC ? 1 : 0);
        drain(70);
        check_q("t4");

        // 'A' with wrong length: dropped only when the type check is built in
        c0 = n_commit; d0 = n_drop;
        hdr(8'h41, 16'd20);
        msg_bytes(20, 8'h80, !TC);
        repeat (2) tick();
        check("t5_commits", 32'(n_commit - c0), TC ? 0 : 1);
        check("t5_drops", 32'(n_drop - d0), TC ? 1 : 0);
        drain(25);
        check_q("t5");

        // Reset with committed data and a partial 'A' pending
        hdr(8'h53, 16'd11);
        msg_bytes(11, 8'h90, 1'b0);
        hdr(8'h41, 16'd35);
        msg_bytes(10, 8'h60, 1'b0);
        check("t6_pre_valid", 32'(bus.out_valid), 1);
        rst = 1'b1;
        tick();
        tick();
        check("t6_rst_valid", 32'(bus.out_valid), 0);
        check("t6_rst_data", 32'(bus.out_data), 0);
        check("t6_rst_last", 32'(bus.out_last), 0);
        check("t6_rst_drop_count", 32'(bus.drop_count), 0);
        check("t6_rst_commit", 32'(bus.msg_commit), 0);
        rst = 1'b0;
        tick();
        c0 = n_commit;
        hdr(8'h45, 16'd30);
        msg_bytes(30, 8'hA0, 1'b1);
        drain(40);
        check("t6_commits", 32'(n_commit - c0), 1);
        check_q("t6");

        // Zero-length header drops in the following cycle
        hdr(8'h44, 16'd0);
        check("t7_drop", 32'(bus.msg_drop), 1);
        check("t7_drop_count", 32'(bus.drop_count), 1);
        tick();
        check("t7_drop_pulse", 32'(bus.msg_drop), 0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        tick();
        bus.rx_valid = 1'b0;
        c0 = n_commit;
        hdr(8'h44, 16'd18);
        msg_bytes(18, 8'hC0, 1'b1);
        drain(25);
        check("t7_commits", 32'(n_commit - c0), 1);
        check_q("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
